gpr_file_sb: RTL and testbench

Parametrised general-purpose register file with N read ports, two write-back ports and a per-register pending-load scoreboard. It sits between decode and write-back of the in-order RISC-V core, replacing the fixed 32x32 two-read/one-write register file. The scoreboard provides the busy indications that the hazard unit uses for load-use interlock. It supports RV32I (32 registers) and RV32E (16 registers) builds.

---
 rtl/riscv_pkg.sv | 24 ++
 rtl/gpr_read_port.sv | 42 ++++
 rtl/gpr_file_sb.sv | 86 ++++++++
 tb/tb_gpr_file_sb.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// Shared core constants and elaboration helpers for the RV32I/RV32E register file.
package riscv_pkg;

    localparam int XLEN_DEF = 32;
    localparam int NREGS_I  = 32;
    localparam int NREGS_E  = 16;
    localparam int REG_ZERO = 0;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) r++;
        return r;
    endfunction

    // Sized for the largest build; smaller vectors are zero-extended by the caller.
    function automatic int popcount(input logic [NREGS_I-1:0] v);
        int c;
        c = 0;
        for (int i = 0; i < NREGS_I; i++) c += int'(v[i]);
        return c;
    endfunction

endpackage

// File: rtl/gpr_read_port.sv
// One register-file read port: x0 check, wb0/wb1 forwarding and pending-load masking.
module gpr_read_port
    import riscv_pkg::*;
#(
    parameter int XLEN  = XLEN_DEF,
    parameter int NREGS = NREGS_I,
    parameter int AW    = clog2(NREGS)
) (
    input  logic             active,
    input  logic [AW-1:0]    addr,
    input  logic [XLEN-1:0]  regs [NREGS],
    input  logic [NREGS-1:0] busy,
    input  logic             wb0_en,
    input  logic [AW-1:0]    wb0_addr,
    input  logic [XLEN-1:0]  wb0_data,
    input  logic             wb1_en,
    input  logic [AW-1:0]    wb1_addr,
    input  logic [XLEN-1:0]  wb1_data,
    output logic [XLEN-1:0]  data,
    output logic             rd_busy
);

    logic wb0_match;
    logic wb1_match;

    assign wb0_match = wb0_en && (wb0_addr == addr);
    assign wb1_match = wb1_en && (wb1_addr == addr);

    // NOTE: every output gets a default first so no path through the block infers a latch.
    always_comb begin
        data    = '0;
        rd_busy = 1'b0;
        if (active && addr != AW'(REG_ZERO)) begin
            if (wb0_match)      data = wb0_data;
            else if (wb1_match) data = wb1_data;
            else                data = regs[addr];
            // A load returning this cycle is forwarded, so it no longer stalls the reader.
            rd_busy = busy[addr] && !wb1_match;
        end
    end

endmodule

// File: rtl/gpr_file_sb.sv
// Parametrised GPR file with N read ports, ALU and load write-back, and a pending-load scoreboard.
module gpr_file_sb
    import riscv_pkg::*;
#(
    parameter int XLEN  = XLEN_DEF,
    parameter int NREGS = NREGS_I,
    parameter int NRD   = 2,
    localparam int AW   = clog2(NREGS)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [NRD*AW-1:0]   rd_addr,
    output logic [NRD*XLEN-1:0] rd_data,
    output logic [NRD-1:0]      rd_busy,
    input  logic                wb0_en,
    input  logic [AW-1:0]       wb0_addr,
    input  logic [XLEN-1:0]     wb0_data,
    input  logic                wb1_en,
    input  logic [AW-1:0]       wb1_addr,
    input  logic [XLEN-1:0]     wb1_data,
    input  logic                iss_en,
    input  logic [AW-1:0]       iss_addr,
    output logic [AW:0]         busy_cnt
);

    logic [XLEN-1:0]  regs [NREGS];
    logic [NREGS-1:0] busy_q;
    logic [NREGS-1:0] busy_next;
    logic             wb0_wr;
    logic             wb1_wr;
    logic             iss_set;

    assign wb0_wr  = wb0_en && (wb0_addr != AW'(REG_ZERO));
    assign wb1_wr  = wb1_en && (wb1_addr != AW'(REG_ZERO));
    assign iss_set = iss_en && (iss_addr != AW'(REG_ZERO));

    // NOTE: the array is reset because reads during and right after reset must return zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREGS; i++) regs[i] <= '0;
        end else begin
            if (wb1_wr) regs[wb1_addr] <= wb1_data;
            // NOTE: the later non-blocking assignment wins, giving wb0 priority on a collision.
            if (wb0_wr) regs[wb0_addr] <= wb0_data;
        end
    end

    // NOTE: blocking assignments in combinational logic; the set follows the clear so a new issue wins.
    always_comb begin
        busy_next = busy_q;
        if (wb1_wr)  busy_next[wb1_addr] = 1'b0;
        if (iss_set) busy_next[iss_addr] = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_q   <= '0;
            busy_cnt <= '0;
        end else begin
            busy_q   <= busy_next;
            busy_cnt <= (AW+1)'(popcount(NREGS_I'(busy_next)));
        end
    end

    for (genvar k = 0; k < NRD; k++) begin : g_rd
        gpr_read_port #(
            .XLEN  (XLEN),
            .NREGS (NREGS),
            .AW    (AW)
        ) u_port (
            .active   (rst_n),
            .addr     (rd_addr[k*AW +: AW]),
            .regs     (regs),
            .busy     (busy_q),
            .wb0_en   (wb0_en),
            .wb0_addr (wb0_addr),
            .wb0_data (wb0_data),
            .wb1_en   (wb1_en),
            .wb1_addr (wb1_addr),
            .wb1_data (wb1_data),
            .data     (rd_data[k*XLEN +: XLEN]),
            .rd_busy  (rd_busy[k])
        );
    end

endmodule

// File: tb/tb_gpr_file_sb.sv
// Bench for gpr_file_sb: RV32I/2-port and RV32E/3-port instances against a behavioural model.
module tb_gpr_file_sb;

    logic clk;
    logic rst_n;

    // RV32I instance, two read ports
    logic [9:0]  rd_addr_i;
    logic [63:0] rd_data_i;
    logic [1:0]  rd_busy_i;
    logic        wb0_en_i, wb1_en_i, iss_en_i;
    logic [4:0]  wb0_addr_i, wb1_addr_i, iss_addr_i;
    logic [31:0] wb0_data_i, wb1_data_i;
    logic [5:0]  busy_cnt_i;

    // RV32E instance, three read ports
    logic [11:0] rd_addr_e;
    logic [95:0] rd_data_e;
    logic [2:0]  rd_busy_e;
    logic        wb0_en_e, wb1_en_e, iss_en_e;
    logic [3:0]  wb0_addr_e, wb1_addr_e, iss_addr_e;
    logic [31:0] wb0_data_e, wb1_data_e;
    logic [4:0]  busy_cnt_e;

    int vectors;
    int errors;

    logic [31:0] m_mem  [32];
    bit          m_busy [32];

    gpr_file_sb #(.XLEN(32), .NREGS(32), .NRD(2)) dut_i (
        .clk(clk), .rst_n(rst_n),
        .rd_addr(rd_addr_i), .rd_data(rd_data_i), .rd_busy(rd_busy_i),
        .wb0_en(wb0_en_i), .wb0_addr(wb0_addr_i), .wb0_data(wb0_data_i),
        .wb1_en(wb1_en_i), .wb1_addr(wb1_addr_i), .wb1_data(wb1_data_i),
        .iss_en(iss_en_i), .iss_addr(iss_addr_i), .busy_cnt(busy_cnt_i)
    );

    gpr_file_sb #(.XLEN(32), .NREGS(16), .NRD(3)) dut_e (
        .clk(clk), .rst_n(rst_n),
        .rd_addr(rd_addr_e), .rd_data(rd_data_e), .rd_busy(rd_busy_e),
        .wb0_en(wb0_en_e), .wb0_addr(wb0_addr_e), .wb0_data(wb0_data_e),
        .wb1_en(wb1_en_e), .wb1_addr(wb1_addr_e), .wb1_data(wb1_data_e),
        .iss_en(iss_en_e), .iss_addr(iss_addr_e), .busy_cnt(busy_cnt_e)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] exp_data(input int a);
        if (!rst_n || a == 0) return 32'h0;
        if (wb0_en_i && int'(wb0_addr_i) == a) return wb0_data_i;
        if (wb1_en_i && int'(wb1_addr_i) == a) return wb1_data_i;
        return m_mem[a];
    endfunction

    function automatic logic exp_busy(input int a);
        if (!rst_n || a == 0) return 1'b0;
        return m_busy[a] && !(wb1_en_i && int'(wb1_addr_i) == a);
    endfunction

    function automatic int model_cnt();
        int c;
        c = 0;
        for (int i = 0; i < 32; i++) if (m_busy[i]) c++;
        return c;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 32; i++) begin
            m_mem[i]  = 32'h0;
            m_busy[i] = 1'b0;
        end
    endtask

    task automatic set_i(input logic e0, input logic [4:0] a0, input logic [31:0] d0,
                         input logic e1, input logic [4:0] a1, input logic [31:0] d1,
                         input logic ei, input logic [4:0] ai,
                         input logic [4:0] r0, input logic [4:0] r1);
        wb0_en_i = e0; wb0_addr_i = a0; wb0_data_i = d0;
        wb1_en_i = e1; wb1_addr_i = a1; wb1_data_i = d1;
        iss_en_i = ei; iss_addr_i = ai;
        rd_addr_i = {r1, r0};
    endtask

    task automatic check_i();
        #1;
        for (int k = 0; k < 2; k++) begin
            int a;
            a = int'(rd_addr_i[k*5 +: 5]);
            check($sformatf("rd_data_i[%0d] x%0d", k, a), rd_data_i[k*32 +: 32], exp_data(a));
            check($sformatf("rd_busy_i[%0d] x%0d", k, a), {31'b0, rd_busy_i[k]}, {31'b0, exp_busy(a)});
        end
    endtask

    // Advance one edge, apply the architectural effect of the held inputs, check the count.
    task automatic clock_i();
        @(posedge clk);
        if (rst_n) begin
            if (wb1_en_i && wb1_addr_i != 0) begin
                m_mem[wb1_addr_i]  = wb1_data_i;
                m_busy[wb1_addr_i] = 1'b0;
            end
            if (wb0_en_i && wb0_addr_i != 0) m_mem[wb0_addr_i] = wb0_data_i;
            if (iss_en_i && iss_addr_i != 0) m_busy[iss_addr_i] = 1'b1;
        end
        #1;
        check("busy_cnt_i", {26'b0, busy_cnt_i}, 32'(model_cnt()));
    endtask

    initial begin
        vectors = 0;
        errors  = 0;
        model_reset();
        rst_n = 1'b0;
        wb0_en_e = 1'b0; wb0_addr_e = '0; wb0_data_e = '0;
        wb1_en_e = 1'b0; wb1_addr_e = '0; wb1_data_e = '0;
        iss_en_e = 1'b0; iss_addr_e = '0; rd_addr_e = '0;

        // Reset held: every address reads zero/not busy even with wb0 and issue active.
        set_i(1, 5'd5, 32'hCAFEF00D, 0, 0, 0, 1, 5'd5, 0, 0);
        wb0_en_e = 1'b1; wb0_addr_e = 4'd5; wb0_data_e = 32'hCAFEF00D;
        for (int a = 0; a < 32; a++) begin
            rd_addr_i = {5'(a), 5'(31 - a)};
            rd_addr_e = {4'(a), 4'(15 - (a % 16)), 4'(a % 16)};
            #1;
            check("rst rd_data_i", rd_data_i[31:0] | rd_data_i[63:32], 32'h0);
            check("rst rd_busy_i", {30'b0, rd_busy_i}, 32'h0);
            check("rst busy_cnt_i", {26'b0, busy_cnt_i}, 32'h0);
            check("rst rd_data_e", rd_data_e[31:0] | rd_data_e[63:32] | rd_data_e[95:64], 32'h0);
            check("rst rd_busy_e", {29'b0, rd_busy_e}, 32'h0);
        end
        set_i(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        wb0_en_e = 1'b0; rd_addr_e = '0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Nothing was written while reset was held.
        set_i(0, 0, 0, 0, 0, 0, 0, 0, 5'd5, 5'd0);
        check_i();
        check("no_write_in_reset", rd_data_i[31:0], 32'h0);
        clock_i();

        // wb0 to x5: same-cycle bypass, then from storage; x0 stays zero.
        set_i(1, 5'd5, 32'hDEADBEEF, 0, 0, 0, 0, 0, 5'd5, 5'd0);
        check_i();
        check("x5_bypass", rd_data_i[31:0], 32'hDEADBEEF);
        clock_i();
        set_i(1, 5'd0, 32'h12345678, 0, 0, 0, 0, 0, 5'd5, 5'd0);
        check_i();
        check("x5_stored", rd_data_i[31:0], 32'hDEADBEEF);
        check("x0_bypass_zero", rd_data_i[63:32], 32'h0);
        clock_i();
        set_i(0, 0, 0, 0, 0, 0, 0, 0, 5'd0, 5'd5);
        check_i();
        check("x0_stored_zero", rd_data_i[31:0], 32'h0);

        // Dual write-back collision on x7: wb0 wins both bypass and storage.
        set_i(1, 5'd7, 32'h11111111, 1, 5'd7, 32'h22222222, 0, 0, 5'd7, 5'd7);
        check_i();
        check("collide_bypass", rd_data_i[63:32], 32'h11111111);
        clock_i();
        set_i(0, 0, 0, 0, 0, 0, 0, 0, 5'd7, 5'd7);
        check_i();
        check("collide_stored", rd_data_i[31:0], 32'h11111111);

        // Load issue to x3, then its write-back clears busy combinationally.
        set_i(0, 0, 0, 0, 0, 0, 1, 5'd3, 5'd3, 5'd0);
        check_i();
        check("x3_not_busy_yet", {31'b0, rd_busy_i[0]}, 32'h0);
        clock_i();
        check("busy_cnt_after_iss", {26'b0, busy_cnt_i}, 32'd1);
        set_i(0, 0, 0, 0, 0, 0, 0, 0, 5'd3, 5'd0);
        check_i();
        check("x3_busy", {31'b0, rd_busy_i[0]}, 32'd1);
        set_i(0, 0, 0, 1, 5'd3, 32'hA5A5A5A5, 0, 0, 5'd3, 5'd0);
        check_i();
        check("x3_wb1_unbusy", {31'b0, rd_busy_i[0]}, 32'h0);
        check("x3_wb1_data", rd_data_i[31:0], 32'hA5A5A5A5);
        clock_i();
        check("busy_cnt_after_wb1", {26'b0, busy_cnt_i}, 32'd0);

        // Set/clear race on x9: the new issue keeps it busy.
        set_i(0, 0, 0, 0, 0, 0, 1, 5'd9, 5'd9, 5'd0);
        check_i();
        clock_i();
        set_i(0, 0, 0, 1, 5'd9, 32'h99990000, 1, 5'd9, 5'd9, 5'd0);
        check_i();
        clock_i();
        check("race_cnt", {26'b0, busy_cnt_i}, 32'd1);
        set_i(0, 0, 0, 0, 0, 0, 0, 0, 5'd9, 5'd0);
        check_i();
        check("race_x9_busy", {31'b0, rd_busy_i[0]}, 32'd1);
        check("race_x9_data", rd_data_i[31:0], 32'h99990000);

        // RV32E, three ports: issues to x1, x15, x14, then asynchronous reset mid-stream.
        iss_en_e = 1'b1; iss_addr_e = 4'd1;
        clock_i();
        check("e_cnt1", {27'b0, busy_cnt_e}, 32'd1);
        iss_addr_e = 4'd15;
        clock_i();
        check("e_cnt2", {27'b0, busy_cnt_e}, 32'd2);
        iss_addr_e = 4'd14;
        clock_i();
        check("e_cnt3", {27'b0, busy_cnt_e}, 32'd3);
        iss_en_e = 1'b0;
        rd_addr_e = {4'd14, 4'd15, 4'd1};
        #1;
        check("e_busy_all", {29'b0, rd_busy_e}, 32'h7);
        wb1_en_e = 1'b1; wb1_addr_e = 4'd15; wb1_data_e = 32'h5555AAAA;
        wb0_en_e = 1'b1; wb0_addr_e = 4'd14; wb0_data_e = 32'h0E0E0E0E;
        #1;
        check("e_busy_fwd", {29'b0, rd_busy_e}, 32'h5);
        check("e_x15_fwd", rd_data_e[63:32], 32'h5555AAAA);
        check("e_x14_wb0", rd_data_e[95:64], 32'h0E0E0E0E);
        wb1_en_e = 1'b0; wb0_en_e = 1'b0;
        #1;
        rst_n = 1'b0;
        #1;
        check("e_rst_cnt", {27'b0, busy_cnt_e}, 32'h0);
        check("e_rst_busy", {29'b0, rd_busy_e}, 32'h0);
        check("i_rst_cnt", {26'b0, busy_cnt_i}, 32'h0);
        check("i_rst_x9", rd_data_i[31:0], 32'h0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        set_i(0, 0, 0, 0, 0, 0, 0, 0, 5'd9, 5'd7);
        check_i();

        // Random traffic with addresses biased toward a small window to force collisions.
        for (int n = 0; n < 400; n++) begin
            logic [4:0] a[5];
            for (int j = 0; j < 5; j++)
                a[j] = ($urandom_range(0, 1) == 0) ? 5'($urandom_range(0, 5)) : 5'($urandom_range(0, 31));
            set_i(1'($urandom_range(0, 1)), a[0], $urandom,
                  1'($urandom_range(0, 1)), a[1], $urandom,
                  1'($urandom_range(0, 1)), a[2], a[3], a[4]);
            check_i();
            clock_i();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
